// File: rtl/systolic_sequencer.sv
// Job controller for one systolic_array: streams K passes of B/A operands from SRAM,
// flushes the array once idle, then forwards its H*W results to the consumer.
module systolic_sequencer #(
   parameter int width_p        = 8,
   parameter int array_width_p  = 2,
   parameter int array_height_p = 2,
   parameter int max_k_p        = 8,
   localparam int kw = $clog2(max_k_p + 1),
   localparam int aw = $clog2(array_height_p * max_k_p),
   localparam int bw = $clog2(max_k_p * array_width_p)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [kw-1:0]      cmd_k_i,
   output logic [aw-1:0]      a_addr_o,
   output logic [bw-1:0]      b_addr_o,
   output logic               a_rd_o,
   output logic               b_rd_o,
   input  logic [width_p-1:0] a_data_i,
   input  logic [width_p-1:0] b_data_i,
   output logic               arr_valid_o,
   output logic [width_p-1:0] arr_data_o,
   input  logic               arr_ready_i,
   input  logic               arr_idle_i,
   output logic               arr_flush_o,
   input  logic               arr_valid_i,
   input  logic [width_p-1:0] arr_data_i,
   output logic               arr_yumi_o,
   output logic               res_valid_o,
   output logic [width_p-1:0] res_data_o,
   input  logic               res_yumi_i,
   output logic               busy_o,
   output logic               done_o
);

   localparam int pass_len = array_width_p + array_height_p;
   localparam int ew = $clog2(pass_len);
   localparam int tw = $clog2(max_k_p * pass_len + 1);
   localparam int rw = $clog2(array_height_p * array_width_p + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FEED, S_WAIT_IDLE, S_FLUSH, S_DRAIN, S_DONE
   } state_e;

   state_e state_r, state_n;

   logic [kw-1:0]      k_r, rd_pass_r;
   logic [ew-1:0]      rd_idx_r;
   logic               rd_done_r;
   logic               vld_p1, sel_a_p1;
   logic [width_p-1:0] fifo_mem [2];
   logic               fifo_wr_r, fifo_rd_r;
   logic [1:0]         fifo_cnt_r;
   logic [tw-1:0]      xfer_cnt_r;
   logic [rw-1:0]      res_cnt_r;

   logic               accept, issue, issue_b, fire, push, pop, last_xfer, last_res;
   logic [width_p-1:0] in_data_p1;
   logic [aw-1:0]      a_addr;
   logic [bw-1:0]      b_addr;

   function automatic logic [kw-1:0] clamp_k(input logic [kw-1:0] k);
      clamp_k = (int'(k) > max_k_p) ? kw'(max_k_p) : k;
   endfunction

   // Stage p0: read issue. Each pass is W B-elements then H A-elements; a read is only
   // issued when the FIFO can take its data even if nothing drains meanwhile.
   assign accept  = cmd_valid_i & cmd_ready_o;
   assign issue_b = int'(rd_idx_r) < array_width_p;
   assign issue   = (state_r == S_FEED) && !rd_done_r &&
                    ((fifo_cnt_r == 2'd0) || ((fifo_cnt_r == 2'd1) && !vld_p1));
   assign a_addr  = aw'((int'(rd_idx_r) - array_width_p) * max_k_p + int'(rd_pass_r));
   assign b_addr  = bw'(int'(rd_pass_r) * array_width_p + int'(rd_idx_r));
   assign a_rd_o   = issue & ~issue_b;
   assign b_rd_o   = issue & issue_b;
   assign a_addr_o = a_rd_o ? a_addr : '0;
   assign b_addr_o = b_rd_o ? b_addr : '0;

   // Stage p1: SRAM data returns; it bypasses the empty FIFO to avoid a bubble.
   assign in_data_p1  = sel_a_p1 ? a_data_i : b_data_i;
   assign arr_valid_o = (fifo_cnt_r != 2'd0) || vld_p1;
   assign arr_data_o  = (fifo_cnt_r != 2'd0) ? fifo_mem[fifo_rd_r] :
                        (vld_p1 ? in_data_p1 : '0);
   assign fire      = arr_valid_o & arr_ready_i;
   assign push      = vld_p1 & ~((fifo_cnt_r == 2'd0) & fire);
   assign pop       = fire & (fifo_cnt_r != 2'd0);
   assign last_xfer = (xfer_cnt_r == tw'(int'(k_r) * pass_len - 1));
   assign last_res  = (res_cnt_r == rw'(array_height_p * array_width_p - 1));
   assign busy_o    = (state_r != S_IDLE);

   always_ff @(posedge clk_i) begin
      if (!reset_i) state_r <= S_IDLE;
      else          state_r <= state_n;
   end

   always_comb begin
      state_n     = state_r;
      cmd_ready_o = 1'b0;
      arr_flush_o = 1'b0;
      arr_yumi_o  = 1'b0;
      res_valid_o = 1'b0;
      res_data_o  = '0;
      done_o      = 1'b0;
      unique case (state_r)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) state_n = (clamp_k(cmd_k_i) == '0) ? S_DONE : S_FEED;
         end
         S_FEED:      if (fire && last_xfer) state_n = S_WAIT_IDLE;
         S_WAIT_IDLE: if (arr_idle_i) state_n = S_FLUSH;
         S_FLUSH: begin
            arr_flush_o = 1'b1;
            state_n     = S_DRAIN;
         end
         S_DRAIN: begin
            res_valid_o = arr_valid_i;
            res_data_o  = arr_data_i;
            arr_yumi_o  = res_yumi_i & arr_valid_i;
            if (res_yumi_i && arr_valid_i && last_res) state_n = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         k_r        <= '0;
         rd_pass_r  <= '0;
         rd_idx_r   <= '0;
         rd_done_r  <= 1'b0;
         vld_p1     <= 1'b0;
         sel_a_p1   <= 1'b0;
         fifo_wr_r  <= 1'b0;
         fifo_rd_r  <= 1'b0;
         fifo_cnt_r <= '0;
         xfer_cnt_r <= '0;
         res_cnt_r  <= '0;
      end else begin
         vld_p1   <= issue;
         sel_a_p1 <= issue & ~issue_b;
         if (accept) begin
            k_r        <= clamp_k(cmd_k_i);
            rd_pass_r  <= '0;
            rd_idx_r   <= '0;
            rd_done_r  <= 1'b0;
            xfer_cnt_r <= '0;
            res_cnt_r  <= '0;
         end
         if (issue) begin
            if (int'(rd_idx_r) == pass_len - 1) begin
               rd_idx_r  <= '0;
               rd_pass_r <= rd_pass_r + 1'b1;
               if (rd_pass_r == k_r - 1'b1) rd_done_r <= 1'b1;
            end else begin
               rd_idx_r <= rd_idx_r + 1'b1;
            end
         end
         if (push) fifo_wr_r <= ~fifo_wr_r;
         if (pop)  fifo_rd_r <= ~fifo_rd_r;
         fifo_cnt_r <= fifo_cnt_r + {1'b0, push} - {1'b0, pop};
         if (fire)       xfer_cnt_r <= xfer_cnt_r + 1'b1;
         if (arr_yumi_o) res_cnt_r  <= res_cnt_r + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[fifo_wr_r] <= in_data_p1;
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized bench for systolic_sequencer: SRAM and systolic_array stand-ins plus a
// matrix-level reference model of the operand stream and the result matrix.
module tb_systolic_sequencer;
   localparam int W = 2, H = 2, MK = 8, DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_i = 1'b0, cmd_valid_i = 1'b0, cmd_ready_o;
   logic [3:0]    cmd_k_i = '0;
   logic [3:0]    a_addr_o, b_addr_o;
   logic          a_rd_o, b_rd_o;
   logic [DW-1:0] a_data_i = '0, b_data_i = '0;
   logic          arr_valid_o, arr_ready_i = 1'b1, arr_idle_i = 1'b1, arr_flush_o;
   logic [DW-1:0] arr_data_o, arr_data_i = '0, res_data_o;
   logic          arr_valid_i = 1'b0, arr_yumi_o, res_valid_o, res_yumi_i = 1'b0;
   logic          busy_o, done_o;

   systolic_sequencer #(.width_p(DW), .array_width_p(W), .array_height_p(H), .max_k_p(MK)) dut (
      .clk_i(clk), .reset_i(reset_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_k_i(cmd_k_i), .a_addr_o(a_addr_o), .b_addr_o(b_addr_o), .a_rd_o(a_rd_o),
      .b_rd_o(b_rd_o), .a_data_i(a_data_i), .b_data_i(b_data_i), .arr_valid_o(arr_valid_o),
      .arr_data_o(arr_data_o), .arr_ready_i(arr_ready_i), .arr_idle_i(arr_idle_i),
      .arr_flush_o(arr_flush_o), .arr_valid_i(arr_valid_i), .arr_data_i(arr_data_i),
      .arr_yumi_o(arr_yumi_o), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
      .res_yumi_i(res_yumi_i), .busy_o(busy_o), .done_o(done_o)
   );

   int unsigned n_vec = 0, n_bad = 0;
   logic [DW-1:0] amat [H][MK];
   logic [DW-1:0] bmat [MK][W];
   logic [DW-1:0] exp_stream[$], exp_c[$], recv[$], rq[$];
   int  xfer_idx, res_idx, flush_cnt, done_cnt, rd_cnt, hold_cnt, idle_cnt = 100, idle_lat = 2;
   int  rmode, ymode, rst_at, cyc = 0, acc_step, first_step, last_step, done_step;
   bit  in_job = 0, start_req = 0, stress = 0, aborted = 0, prev_stall = 0;
   logic [3:0]    start_k;
   logic [DW-1:0] prev_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < H; i++) for (int k = 0; k < MK; k++) amat[i][k] = 8'($urandom);
      for (int k = 0; k < MK; k++) for (int j = 0; j < W; j++) bmat[k][j] = 8'($urandom);
   endtask

   task automatic fill_fixed();
      amat[0][0] = 1; amat[0][1] = 2; amat[1][0] = 3; amat[1][1] = 4;
      bmat[0][0] = 1; bmat[0][1] = 2; bmat[1][0] = 3; bmat[1][1] = 4;
   endtask

   // Expected operand order and C = A*B (mod 2^DW), straight from the matrices.
   task automatic build_expect(input int k);
      int acc;
      exp_stream.delete();
      exp_c.delete();
      for (int p = 0; p < k; p++) begin
         for (int j = 0; j < W; j++) exp_stream.push_back(bmat[p][j]);
         for (int i = 0; i < H; i++) exp_stream.push_back(amat[i][p]);
      end
      if (k > 0)
         for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
               acc = 0;
               for (int p = 0; p < k; p++) acc += int'(amat[i][p]) * int'(bmat[p][j]);
               exp_c.push_back(8'(acc));
            end
   endtask

   // Array stand-in: derives its results purely from the operands it actually received.
   task automatic mock_compute();
      int np;
      int acc [H][W];
      np = recv.size() / (W + H);
      for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) acc[i][j] = 0;
      for (int p = 0; p < np; p++)
         for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
               acc[i][j] += int'(recv[p*(W+H) + W + i]) * int'(recv[p*(W+H) + j]);
      for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) rq.push_back(8'(acc[i][j]));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, {31'd0, cmd_ready_o}, 32'd1);
      check({tag, "_outs"}, {busy_o, a_rd_o, b_rd_o, a_addr_o, b_addr_o, arr_valid_o, arr_data_o,
                             arr_flush_o, arr_yumi_o, res_valid_o, res_data_o, done_o}, 32'd0);
   endtask

   task automatic step();
      bit do_rst, rd_a, rd_b, fire, popped, flushed;
      logic [3:0] aa, ba;
      @(negedge clk);
      reset_i = 1'b1;
      case (rmode)
         0:       arr_ready_i = 1'b1;
         1:       arr_ready_i = ~arr_ready_i;
         default: arr_ready_i = 1'($urandom_range(0, 1));
      endcase
      case (ymode)
         0:       res_yumi_i = 1'b1;
         1:       res_yumi_i = (hold_cnt >= 5);
         default: res_yumi_i = 1'($urandom_range(0, 1));
      endcase
      if (start_req) begin
         cmd_valid_i = 1'b1;
         cmd_k_i     = start_k;
      end else if (in_job && stress) begin
         cmd_valid_i = 1'($urandom_range(0, 1));
         cmd_k_i     = 4'($urandom);
      end else begin
         cmd_valid_i = 1'b0;
      end
      do_rst = in_job && (rst_at >= 0) && (xfer_idx == rst_at);
      if (do_rst) begin
         reset_i     = 1'b0;
         cmd_valid_i = 1'b0;
      end
      #1;
      check("cmd_ready", {31'd0, cmd_ready_o}, {31'd0, !in_job});
      check("busy", {31'd0, busy_o}, {31'd0, in_job});
      check("one_read", {31'd0, a_rd_o & b_rd_o}, 32'd0);
      rd_a = a_rd_o; rd_b = b_rd_o; aa = a_addr_o; ba = b_addr_o;
      fire = 0; popped = 0; flushed = 0;
      if (do_rst) begin
         in_job = 0; aborted = 1; prev_stall = 0; rd_a = 0; rd_b = 0;
         recv.delete();
         rq.delete();
      end else begin
         if (prev_stall) begin
            check("stall_valid", {31'd0, arr_valid_o}, 32'd1);
            check("stall_data", {24'd0, arr_data_o}, {24'd0, prev_data});
         end
         if (arr_valid_o && first_step < 0) first_step = cyc;
         if (arr_valid_o && arr_ready_i) begin
            fire = 1;
            last_step = cyc;
            if (xfer_idx < exp_stream.size())
               check($sformatf("elem%0d", xfer_idx), {24'd0, arr_data_o}, {24'd0, exp_stream[xfer_idx]});
            else
               check("elem_count", xfer_idx + 1, exp_stream.size());
            recv.push_back(arr_data_o);
            xfer_idx++;
         end
         prev_stall = arr_valid_o && !arr_ready_i;
         prev_data  = arr_data_o;
         rd_cnt += int'(rd_a | rd_b);
         if (arr_flush_o) begin
            flushed = 1;
            flush_cnt++;
            check("flush_after_feed", recv.size(), exp_stream.size());
         end
         check("res_valid", {31'd0, res_valid_o}, {31'd0, arr_valid_i});
         check("arr_yumi", {31'd0, arr_yumi_o}, {31'd0, arr_valid_i & res_yumi_i});
         if (arr_valid_i) begin
            if (res_idx < exp_c.size())
               check($sformatf("res%0d", res_idx), {24'd0, res_data_o}, {24'd0, exp_c[res_idx]});
            else
               check("res_count", res_idx + 1, exp_c.size());
            if (res_yumi_i) begin
               res_idx++;
               popped = 1;
            end else begin
               hold_cnt++;
            end
         end
         if (done_o) begin
            done_cnt++;
            done_step = cyc;
         end
         if (cmd_valid_i && cmd_ready_o) begin
            in_job = 1; start_req = 0; acc_step = cyc;
         end else if (done_o) begin
            in_job = 0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
      a_data_i = rd_a ? amat[aa / MK][aa % MK] : 8'($urandom);
      b_data_i = rd_b ? bmat[ba / W][ba % W] : 8'($urandom);
      if (flushed) mock_compute();
      if (popped && rq.size() > 0) void'(rq.pop_front());
      arr_valid_i = (rq.size() > 0);
      arr_data_i  = arr_valid_i ? rq[0] : 8'($urandom);
      idle_cnt    = fire ? 0 : idle_cnt + 1;
      arr_idle_i  = (idle_cnt >= idle_lat);
   endtask

   task automatic run_job(input int k, input int rm, input int ym, input bit st, input int rp);
      int kc;
      bit fin;
      kc = (k > MK) ? MK : k;
      build_expect(kc);
      rmode = rm; ymode = ym; stress = st; rst_at = rp;
      hold_cnt = 0; xfer_idx = 0; res_idx = 0; flush_cnt = 0; done_cnt = 0; rd_cnt = 0;
      aborted = 0; first_step = -1; acc_step = -1; last_step = -1; done_step = -1;
      idle_lat = $urandom_range(1, 4);
      recv.delete();
      rq.delete();
      start_k = 4'(k);
      start_req = 1;
      fin = 0;
      for (int c = 0; c < 400 && !fin; c++) begin
         step();
         fin = (acc_step >= 0) && !in_job;
      end
      check("job_finished", {31'd0, fin}, 32'd1);
      if (!aborted) begin
         check("done_once", done_cnt, 1);
         check("flush_cnt", flush_cnt, (kc > 0) ? 1 : 0);
         check("elems", xfer_idx, kc * (W + H));
         check("reads", rd_cnt, kc * (W + H));
         check("results", res_idx, (kc > 0) ? H * W : 0);
         if (kc > 0) check("first_lat", first_step - acc_step, 2);
         if (kc > 0 && rm == 0) check("throughput", last_step - first_step, kc * (W + H) - 1);
         if (kc == 0) check("k0_done_lat", {31'd0, (done_step - acc_step) <= 2}, 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rmode = 0; ymode = 0; rst_at = -1;
      fill_rand();
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");

      fill_fixed();
      run_job(2, 0, 0, 0, -1);   // full-throughput reference job
      run_job(2, 1, 0, 0, -1);   // ready toggling every cycle
      run_job(2, 0, 1, 0, -1);   // consumer holds off first result for 5 cycles
      run_job(0, 2, 2, 0, -1);   // empty job
      fill_rand();
      run_job(2, 2, 2, 1, 3);    // reset after three transfers
      check_idle("abort");
      fill_fixed();
      run_job(2, 0, 0, 0, -1);
      run_job(2, 2, 2, 1, -1);   // stray commands throughout the job
      fill_rand();
      run_job(12, 2, 2, 1, -1);  // oversized K is clamped
      for (int n = 0; n < 10; n++) begin
         fill_rand();
         run_job($urandom_range(0, MK), $urandom_range(0, 2), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
